load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 65 ++++++
 rtl/load_store_unit.sv | 128 ++++++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RV32I
// funct3 access codes, default memory timeout and the access legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } lsu_state_e;

  // Load encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int LSU_TIMEOUT = 16;

  // True when funct3 is a defined access for the direction and the byte
  // offset respects the natural alignment of the access size.
  function automatic logic access_ok(input logic [2:0] f3,
                                     input logic       is_store,
                                     input logic [1:0] off);
    logic ok;
    case (f3)
      LB, LBU: ok = !(is_store && f3[2]);
      LH, LHU: ok = !(is_store && f3[2]) && !off[0];
      LW:      ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//   funct3  : access size/sign of the latched request
//   offset  : byte offset within the word (addr[1:0])
//   store   : 1 for a store, 0 for a load
//   sdata   : store data from the register file
//   ldata   : raw word returned by memory
//   be      : byte enables (all ones for loads)
//   wdata   : store data replicated across the word
//   lresult : selected load lane, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic [2:0]           funct3,
  input  logic [1:0]           offset,
  input  logic                 store,
  input  logic [DATAWIDTH-1:0] sdata,
  input  logic [DATAWIDTH-1:0] ldata,
  output logic [3:0]           be,
  output logic [DATAWIDTH-1:0] wdata,
  output logic [DATAWIDTH-1:0] lresult
);

  logic [DATAWIDTH-1:0] lshift;
  logic signed [7:0]    lbyte;
  logic signed [15:0]   lhalf;

  always_comb begin
    be    = 4'b1111;
    wdata = sdata;
    if (store) begin
      case (funct3)
        SB: begin
          be    = 4'b0001 << offset;
          wdata = {(DATAWIDTH/8){sdata[7:0]}};
        end
        SH: begin
          be    = offset[1] ? 4'b1100 : 4'b0011;
          wdata = {(DATAWIDTH/16){sdata[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = sdata;
        end
      endcase
    end
  end

  // Bring the addressed lane down to bit 0, then extend by access type.
  always_comb begin
    lshift  = ldata >> {offset, 3'b000};
    lbyte   = lshift[7:0];
    lhalf   = lshift[15:0];
    lresult = ldata;
    case (funct3)
      LB:      lresult = {{(DATAWIDTH-8){lbyte[7]}}, lbyte};
      LH:      lresult = {{(DATAWIDTH-16){lhalf[15]}}, lhalf};
      LBU:     lresult = {{(DATAWIDTH-8){1'b0}}, lshift[7:0]};
      LHU:     lresult = {{(DATAWIDTH-16){1'b0}}, lshift[15:0]};
      default: lresult = ldata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a req/ack data memory.
//   clk, rst                 : clock, synchronous active-high reset
//   start, MemRead, MemWrite : request handshake from execute
//   funct3, ALUout, regOp2   : access type, byte address, store data
//   busy, done, err          : stall, completion pulse, fault pulse
//   rdata                    : extended load result, held until next load
//   mem_req/we/addr/wdata/be : memory request, stable while in REQ
//   mem_ack, mem_rdata       : memory response
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = LSU_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [2:0]           funct3,
  input  logic [DATAWIDTH-1:0] ALUout,
  input  logic [DATAWIDTH-1:0] regOp2,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATAWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  output logic [3:0]           mem_be,
  input  logic                 mem_ack,
  input  logic [DATAWIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e           state, state_n;
  logic [CNT_W-1:0]     tmo_cnt;
  logic                 accept;

  logic [DATAWIDTH-1:0] addr_p0;
  logic [DATAWIDTH-1:0] sdata_p0;
  logic [2:0]           f3_p0;
  logic                 we_p0;

  logic [3:0]           be;
  logic [DATAWIDTH-1:0] wdata;
  logic [DATAWIDTH-1:0] lresult;

  // Next-state logic. A store wins when both MemRead and MemWrite are set.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start && (MemRead || MemWrite)) begin
          if (access_ok(funct3, MemWrite, ALUout[1:0])) begin
            accept  = 1'b1;
            state_n = REQ;
          end else begin
            state_n = ERR;
          end
        end
      end
      REQ: begin
        if (mem_ack)
          state_n = DONE;
        else if (tmo_cnt == CNT_W'(TIMEOUT - 1))
          state_n = ERR;
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      rdata   <= '0;
    end else begin
      state <= state_n;
      if (state == REQ)
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      else
        tmo_cnt <= '0;
      if (state == REQ && mem_ack && !we_p0)
        rdata <= lresult;
    end
  end

  // Stage p0: request captured on acceptance, held for the whole REQ phase.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= ALUout;
      sdata_p0 <= regOp2;
      f3_p0    <= funct3;
      we_p0    <= MemWrite;
    end
  end

  lsu_align #(
    .DATAWIDTH(DATAWIDTH)
  ) u_align (
    .funct3 (f3_p0),
    .offset (addr_p0[1:0]),
    .store  (we_p0),
    .sdata  (sdata_p0),
    .ldata  (mem_rdata),
    .be     (be),
    .wdata  (wdata),
    .lresult(lresult)
  );

  // Memory-side outputs are forced to zero outside REQ so nothing stale
  // leaks out after reset or between transactions.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & we_p0;
  assign mem_addr  = mem_req ? {addr_p0[DATAWIDTH-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be : 4'b0000;
  assign mem_wdata = (mem_req && we_p0) ? wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst, start, MemRead, MemWrite;
  logic [2:0]    funct3;
  logic [DW-1:0] ALUout, regOp2;
  logic          busy, done, err;
  logic [DW-1:0] rdata;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  // Transaction-level expectations
  logic        exp_legal, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rdata, model_rdata;
  logic [3:0]  exp_be;
  logic        cmp_en = 1'b0;
  logic        saw_req;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;

  always #5 clk = ~clk;

  load_store_unit #(.DATAWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUout(ALUout), .regOp2(regOp2),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: what a request should look like on the memory side and
  // what rdata should read once it completes.
  task automatic set_model(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] w);
    int nb, off, bem;
    logic [31:0] v;
    off = int'(a % 4);
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    exp_legal = (rd || wr) && !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)
                && !(wr && f3[2]) && (off % nb == 0);
    exp_we   = wr;
    exp_addr = a - 32'(off);
    if (wr) begin
      bem    = ((1 << nb) - 1) << off;
      exp_be = bem[3:0];
      for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = d[8*(i % nb) +: 8];
      exp_rdata = model_rdata;
    end else begin
      exp_be    = 4'hF;
      exp_wdata = 32'h0;
      v = w >> (8 * off);
      if (nb == 1) begin
        v = v & 32'h0000_00FF;
        if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else if (nb == 2) begin
        v = v & 32'h0000_FFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      exp_rdata = v;
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      if (mem_req) begin
        saw_req    = 1'b1;
        last_addr  = mem_addr;
        last_be    = mem_be;
        last_wdata = mem_wdata;
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", {28'h0, mem_be}, {28'h0, exp_be});
        chk("mem_we", {31'h0, mem_we}, {31'h0, exp_we});
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (done) chk("rdata_at_done", rdata, exp_rdata);
      if (!busy) begin
        chk("idle_rdata", rdata, model_rdata);
        chk("idle_req", {31'h0, mem_req}, 32'h0);
        chk("idle_done_err", {30'h0, done, err}, 32'h0);
      end
    end
  end

  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] w,
                         input int lat, output int cyc);
    int  reqcnt, expcyc;
    logic fin, exp_done;
    set_model(rd, wr, f3, a, d, w);
    saw_req  = 1'b0;
    start    = 1'b1; MemRead = rd; MemWrite = wr;
    funct3   = f3;   ALUout  = a;  regOp2   = d;
    mem_ack  = $urandom_range(0, 1);
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 0;
    if (!rd && !wr) begin
      chk("ignore_busy", {31'h0, busy}, 32'h0);
      @(posedge clk); #1;
      chk("ignore_busy2", {31'h0, busy}, 32'h0);
      return;
    end
    cyc = 1; reqcnt = 0; fin = 1'b0;
    while (!fin && cyc <= TO + 8) begin
      if (done || err) fin = 1'b1;
      else begin
        chk("busy_in_txn", {31'h0, busy}, 32'h1);
        chk("req_in_txn", {31'h0, mem_req}, {31'h0, exp_legal});
        mem_ack   = mem_req && (reqcnt == lat);
        mem_rdata = mem_ack ? w : $urandom;
        if (mem_req) reqcnt++;
        start  = $urandom_range(0, 1); MemRead = $urandom_range(0, 1);
        MemWrite = $urandom_range(0, 1); funct3 = 3'($urandom);
        ALUout = $urandom; regOp2 = $urandom;
        @(posedge clk); #1;
        cyc++;
      end
    end
    exp_done = exp_legal && (lat < TO);
    expcyc   = !exp_legal ? 1 : (lat < TO) ? lat + 2 : TO + 1;
    chk("finished", {31'h0, fin}, 32'h1);
    chk("end_cycle", cyc, expcyc);
    chk("done_flag", {31'h0, done}, {31'h0, exp_done});
    chk("err_flag", {31'h0, err}, {31'h0, !exp_done});
    chk("end_req", {31'h0, mem_req}, 32'h0);
    if (exp_done && !wr) model_rdata = exp_rdata;
    start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    mem_ack = $urandom_range(0, 1);
    @(posedge clk); #1;
    chk("post_busy", {31'h0, busy}, 32'h0);
    chk("post_pulse", {30'h0, done, err}, 32'h0);
    mem_ack = 1'b0;
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    funct3 = 3'd0; ALUout = '0; regOp2 = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {28'h0, busy, done, err, mem_req}, 32'h0);
    chk("rst_we_be", {27'h0, mem_we, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // Pinned literal cases
    run_txn(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, c);
    chk("sw_be", {28'h0, last_be}, 32'hF);
    chk("sw_addr", last_addr, 32'h100);
    chk("sw_wdata", last_wdata, 32'hDEADBEEF);
    chk("sw_cycles", c, 4);
    chk("sw_rdata", rdata, 32'h0);

    run_txn(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, c);
    chk("sb_be", {28'h0, last_be}, 32'h8);
    chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
    chk("sb_addr", last_addr, 32'h100);
    chk("sb_cycles", c, 2);

    run_txn(1'b1, 1'b0, 3'b000, 32'h202, 32'h0, 32'h0080FF00, 1, c);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    run_txn(1'b1, 1'b0, 3'b100, 32'h202, 32'h0, 32'h0080FF00, 3, c);
    chk("lbu_rdata", rdata, 32'h00000080);

    run_txn(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h12345678, 0, c);
    chk("lw_mis_cycles", c, 1);
    chk("lw_mis_noreq", {31'h0, saw_req}, 32'h0);
    chk("lw_mis_busy_n2", {31'h0, busy}, 32'h0);
    chk("lw_mis_rdata", rdata, 32'h00000080);

    run_txn(1'b1, 1'b0, 3'b001, 32'h204, 32'h0, 32'h0, 100, c);
    chk("lh_tmo_cycles", c, 17);
    chk("lh_tmo_rdata", rdata, 32'h00000080);

    // Reset in the middle of a request
    set_model(1'b1, 1'b0, 3'b001, 32'h208, 32'h0, 32'h0);
    start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b001; ALUout = 32'h208;
    @(posedge clk); #1;
    start = 1'b0; MemRead = 1'b0;
    repeat (3) begin
      chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    model_rdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_req", {31'h0, mem_req}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    repeat (3) begin
      chk("midrst_nopulse", {30'h0, done, err}, 32'h0);
      @(posedge clk); #1;
    end
    run_txn(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 1, c);
    chk("after_rst_rdata", rdata, 32'hCAFEF00D);
    chk("after_rst_cycles", c, 3);

    // Randomized traffic
    for (int k = 0; k < 80; k++) begin
      logic [31:0] ra;
      int lat;
      ra  = $urandom;
      lat = ($urandom_range(0, 7) == 0) ? TO + 2 : $urandom_range(0, 4);
      run_txn(1'($urandom), 1'($urandom), 3'($urandom), ra, $urandom, $urandom, lat, c);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
